// File: rtl/bus_master_req.sv
// Requester-side bus agent: requests the shared bus, waits for grant, drives a framed burst.
// Optional grant-wait timeout enabled by defining BUS_REQ_TIMEOUT_EN.
module bus_master_req #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEN_W       = 3,
  parameter int unsigned REQ_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              req,
  input  logic              grant,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              bus_last,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_last_q, bus_last_d;
  logic                timed_out_q, timed_out_d;
  logic                beat;
  logic                expired;

  assign beat = (state_q == StXfer) && grant && wr_valid;

`ifdef BUS_REQ_TIMEOUT_EN
  localparam int unsigned CntW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  logic [CntW-1:0] wait_q, wait_d;

  // Counter holds the number of grant-less REQ cycles already completed.
  always_comb begin
    wait_d = wait_q;
    if (state_q == StIdle) begin
      wait_d = '0;
    end else if (state_q == StReq && !grant) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Grant in the expiry cycle wins because StReq checks grant first.
  assign expired = (state_q == StReq) && !grant && (wait_q == CntW'(REQ_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign timeout = (state_q == StRel) && timed_out_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^REQ_TIMEOUT;
  assign expired            = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = 1'b0;
    bus_last_d  = 1'b0;
    timed_out_d = timed_out_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          remaining_d = cmd_len;
          timed_out_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (grant) begin
          state_d = StXfer;
        end else if (expired) begin
          timed_out_d = 1'b1;
          state_d     = StRel;
        end
      end
      StXfer: begin
        // Grant loss only pauses the burst; remaining holds until grant returns.
        if (beat) begin
          bus_data_d  = wr_data;
          bus_valid_d = 1'b1;
          if (remaining_q == '0) begin
            bus_last_d = 1'b1;
            state_d    = StRel;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      StRel: begin
        timed_out_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      bus_last_q  <= bus_last_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign req       = (state_q == StReq) || (state_q == StXfer);
  assign wr_ready  = (state_q == StXfer) && grant;
  assign done      = (state_q == StRel) && !timed_out_q;
  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;
  assign bus_last  = bus_last_q;

endmodule
